mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/lc3b_types.sv | 47 ++++
 rtl/mem_data_align.sv | 28 ++
 rtl/mem_access_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: data word, opcode encoding, decoded control word
// and the memory-access FSM state used by the MEM stage.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       mem_read;
    logic       mem_write;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE,
    INDIRECT,
    ACCESS,
    DONE
  } lc3b_mem_state;

  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

  function automatic logic is_indirect_op(input lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/mem_data_align.sv
// Byte-lane selection for stores and load-result formatting for the MEM stage.
// Purely combinational; word ops pass straight through.
module mem_data_align
  import lc3b_types::*;
(
  input  lc3b_opcode  opcode,
  input  logic        addr_lsb,
  input  lc3b_word    wdata,
  input  lc3b_word    rdata,
  output logic [1:0]  byte_enable,
  output lc3b_word    wdata_fmt,
  output lc3b_word    rdata_fmt
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    byte_enable = 2'b11;
    wdata_fmt   = wdata;
    rdata_fmt   = rdata;
    if (is_byte_op(opcode)) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
      // Replicate the byte so it lands correctly whichever lane is enabled.
      wdata_fmt   = {wdata[7:0], wdata[7:0]};
      rdata_fmt   = {8'h00, (addr_lsb ? rdata[15:8] : rdata[7:0])};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage data-memory sequencer: word, byte and indirect loads/stores
// against a variable-latency memory, stalling the pipeline while busy.
module mem_access_unit
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_valid,
  input  lc3b_control_word ctrl,
  input  lc3b_word         address,
  input  lc3b_word         wdata,
  input  logic             dmem_resp,
  input  lc3b_word         dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output lc3b_word         dmem_address,
  output lc3b_word         dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  output logic             stall,
  output lc3b_word         rdata_out,
  output logic             done
);

  lc3b_mem_state state;
  lc3b_word      addr_q;
  lc3b_word      wdata_q;
  lc3b_opcode    opcode_q;
  logic          is_read_q;

  logic          accept;
  logic [1:0]    lane_be;
  lc3b_word      wdata_fmt;
  lc3b_word      rdata_fmt;

  assign accept = (state == IDLE) && ctrl_valid && (ctrl.mem_read || ctrl.mem_write);

  mem_data_align u_align (
    .opcode      (opcode_q),
    .addr_lsb    (addr_q[0]),
    .wdata       (wdata_q),
    .rdata       (dmem_rdata),
    .byte_enable (lane_be),
    .wdata_fmt   (wdata_fmt),
    .rdata_fmt   (rdata_fmt)
  );

  // NOTE: state is updated with non-blocking assignments and cleared by the async
  // reset, so the bus strobes decoded from it drop the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      opcode_q  <= op_br;
      is_read_q <= 1'b0;
      rdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= address;
            wdata_q   <= wdata;
            opcode_q  <= ctrl.opcode;
            is_read_q <= ctrl.mem_read;
            state     <= is_indirect_op(ctrl.opcode) ? INDIRECT : ACCESS;
          end
        end
        INDIRECT: begin
          // The pointer fetched here becomes the effective address of the access.
          if (dmem_resp) begin
            addr_q <= dmem_rdata;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            if (is_read_q) rdata_out <= rdata_fmt;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b00;
    dmem_address     = {addr_q[15:1], 1'b0};
    dmem_wdata       = wdata_fmt;
    stall            = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE:     stall = accept;
      INDIRECT: begin
        dmem_read        = 1'b1;
        dmem_byte_enable = 2'b11;
        stall            = 1'b1;
      end
      ACCESS: begin
        dmem_read        = is_read_q;
        dmem_write       = ~is_read_q;
        dmem_byte_enable = lane_be;
        stall            = 1'b1;
      end
      DONE:     done = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

endmodule
